// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a big-endian 32-bit word stream into 512-bit
// blocks and appends the 0x80 marker, zero fill and the 64-bit bit length.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output logic         busy
);

    typedef enum logic [1:0] {FILL, OUT, EXTRA} state_t;

    state_t            state_reg;
    logic [31:0]       blk_buf_reg [16];
    logic [3:0]        widx_reg;
    logic [LEN_W-1:0]  len_reg;
    logic              first_pending_reg;
    logic              extra_pending_reg;
    logic              pad_pending_reg;
    logic              in_ready_reg;
    logic              blk_valid_reg;
    logic              blk_first_reg;
    logic              blk_last_reg;
    logic              busy_reg;

    logic [2:0]        n_bytes;
    logic [31:0]       keep_mask;
    logic [31:0]       marker;
    logic [6:0]        blk_bytes;
    logic [LEN_W-1:0]  len_next;
    logic [63:0]       len_field_next;
    logic [63:0]       len_field_cur;
    logic              accept;

    always_comb begin
        n_bytes   = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        keep_mask = 32'h0000_0000;
        marker    = 32'h0000_0000;
        // Keep the n leading bytes; the marker lands right after them when it fits this word.
        case (n_bytes)
            3'd0: begin keep_mask = 32'h0000_0000; marker = 32'h8000_0000; end
            3'd1: begin keep_mask = 32'hFF00_0000; marker = 32'h0080_0000; end
            3'd2: begin keep_mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
            3'd3: begin keep_mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
            default: begin keep_mask = 32'hFFFF_FFFF; marker = 32'h0000_0000; end
        endcase
        blk_bytes = {1'b0, widx_reg, 2'b00} + {4'b0000, n_bytes};
        accept    = in_valid && in_ready_reg;
        if (in_last) begin
            len_next = len_reg + LEN_W'({n_bytes, 3'b000});
        end else begin
            len_next = len_reg + LEN_W'(6'd32);
        end
        len_field_next = 64'(len_next);
        len_field_cur  = 64'(len_reg);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= FILL;
            for (int i = 0; i < 16; i++) begin
                blk_buf_reg[i] <= 32'h0000_0000;
            end
            widx_reg          <= 4'd0;
            len_reg           <= '0;
            first_pending_reg <= 1'b1;
            extra_pending_reg <= 1'b0;
            pad_pending_reg   <= 1'b0;
            in_ready_reg      <= 1'b0;
            blk_valid_reg     <= 1'b0;
            blk_first_reg     <= 1'b0;
            blk_last_reg      <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        busy_reg <= 1'b1;
                        len_reg  <= len_next;
                        widx_reg <= widx_reg + 4'd1;
                        if (!in_last) begin
                            blk_buf_reg[widx_reg] <= in_data;
                            if (widx_reg == 4'd15) begin
                                state_reg     <= OUT;
                                in_ready_reg  <= 1'b0;
                                blk_valid_reg <= 1'b1;
                                blk_first_reg <= first_pending_reg;
                                blk_last_reg  <= 1'b0;
                            end
                        end else begin
                            blk_buf_reg[widx_reg] <= (in_data & keep_mask) | marker;
                            // A full final word pushes the marker into the next word, or the next block.
                            if (n_bytes == 3'd4) begin
                                if (widx_reg != 4'd15) begin
                                    blk_buf_reg[widx_reg + 4'd1] <= 32'h8000_0000;
                                end else begin
                                    pad_pending_reg <= 1'b1;
                                end
                            end
                            if (blk_bytes <= 7'd55) begin
                                blk_buf_reg[14] <= len_field_next[63:32];
                                blk_buf_reg[15] <= len_field_next[31:0];
                                blk_last_reg    <= 1'b1;
                            end else begin
                                blk_last_reg      <= 1'b0;
                                extra_pending_reg <= 1'b1;
                            end
                            state_reg     <= OUT;
                            in_ready_reg  <= 1'b0;
                            blk_valid_reg <= 1'b1;
                            blk_first_reg <= first_pending_reg;
                        end
                    end
                end
                OUT: begin
                    if (blk_ready) begin
                        for (int i = 0; i < 16; i++) begin
                            blk_buf_reg[i] <= 32'h0000_0000;
                        end
                        widx_reg          <= 4'd0;
                        first_pending_reg <= 1'b0;
                        blk_valid_reg     <= 1'b0;
                        blk_first_reg     <= 1'b0;
                        blk_last_reg      <= 1'b0;
                        if (extra_pending_reg) begin
                            state_reg <= EXTRA;
                        end else begin
                            state_reg    <= FILL;
                            in_ready_reg <= 1'b1;
                            if (blk_last_reg) begin
                                len_reg           <= '0;
                                first_pending_reg <= 1'b1;
                                busy_reg          <= 1'b0;
                            end
                        end
                    end
                end
                EXTRA: begin
                    blk_buf_reg[0]    <= pad_pending_reg ? 32'h8000_0000 : 32'h0000_0000;
                    blk_buf_reg[14]   <= len_field_cur[63:32];
                    blk_buf_reg[15]   <= len_field_cur[31:0];
                    extra_pending_reg <= 1'b0;
                    pad_pending_reg   <= 1'b0;
                    state_reg         <= OUT;
                    blk_valid_reg     <= 1'b1;
                    blk_first_reg     <= first_pending_reg;
                    blk_last_reg      <= 1'b1;
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_blk_word
            assign blk_data[511 - 32*gi -: 32] = blk_buf_reg[gi];
        end
    endgenerate

    assign in_ready  = in_ready_reg;
    assign blk_valid = blk_valid_reg;
    assign blk_first = blk_first_reg;
    assign blk_last  = blk_last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: random messages against a byte-level padding model,
// plus directed corner messages, backpressure and mid-message reset.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         busy;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [511:0] exp_q[$];
    bit           exp_first_q[$];
    bit           exp_last_q[$];
    logic [31:0]  cur_words[$];
    logic [2:0]   cur_nraw;
    bit           bp_mode = 1'b0;

    function automatic void check(input bit ok, input string name,
                                  input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Padding model: flatten the message to bytes, then append 0x80, zeros to 56 mod 64, length.
    task automatic model_build(output int base, output int nblk);
        logic [7:0]   bq[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        int nb;
        base = exp_q.size();
        for (int i = 0; i < cur_words.size(); i++) begin
            nb = 4;
            if (i == cur_words.size() - 1) nb = (cur_nraw > 3'd4) ? 4 : int'(cur_nraw);
            for (int k = 0; k < nb; k++) bq.push_back(cur_words[i][31 - 8*k -: 8]);
        end
        bits = 64'(bq.size()) * 64'd8;
        bq.push_back(8'h80);
        while (bq.size() % 64 != 56) bq.push_back(8'h00);
        for (int k = 0; k < 8; k++) bq.push_back(bits[63 - 8*k -: 8]);
        nblk = bq.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int k = 0; k < 64; k++) blk[511 - 8*k -: 8] = bq[b*64 + k];
            exp_q.push_back(blk);
            exp_first_q.push_back(b == 0);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    task automatic set_msg(input int nfull, input logic [2:0] nraw);
        cur_words.delete();
        for (int i = 0; i <= nfull; i++) cur_words.push_back($urandom);
        cur_nraw = nraw;
    endtask

    // Feeds cur_words; stops after abort_after accepted words when abort_after >= 0.
    task automatic feed(input int abort_after);
        int t;
        int last_i;
        last_i = cur_words.size() - 1;
        for (int i = 0; i <= last_i; i++) begin
            if (i == abort_after) return;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = cur_words[i];
            in_last  = (i == last_i);
            in_bytes = (i == last_i) ? cur_nraw : 3'($urandom);
            t = 0;
            while (!in_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check(1'b0, "in_ready_timeout", 512'(t), 512'(500));
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i == 0) check(busy == 1'b1, "busy_after_first_word", 512'(busy), 512'(1));
            if (i == last_i || (i % 16) == 15)
                check(blk_valid == 1'b1, "block_latency", 512'(blk_valid), 512'(1));
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(exp_q.size() == 0, "drain_timeout", 512'(exp_q.size()), 512'(0));
        repeat (2) @(negedge clk);
        check(busy == 1'b0, "busy_after_last", 512'(busy), 512'(0));
        check(in_ready == 1'b1, "in_ready_idle", 512'(in_ready), 512'(1));
    endtask

    // Block-side driver and compare process.
    initial begin
        bit           prev_valid = 1'b0;
        bit           prev_ready = 1'b0;
        logic [511:0] held_data = '0;
        bit           held_first = 1'b0;
        bit           held_last = 1'b0;
        int           hold_cnt = 0;
        logic [511:0] e;
        bit           ef, el;
        blk_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0;
                blk_ready  = 1'b0;
                continue;
            end
            if (blk_valid && !prev_valid) hold_cnt = bp_mode ? 5 : 0;
            if (hold_cnt > 0) begin
                blk_ready = 1'b0;
                hold_cnt--;
            end else begin
                blk_ready = bp_mode ? 1'b1 : ($urandom_range(0, 99) < 60);
            end
            if (blk_valid) begin
                check(in_ready == 1'b0, "in_ready_while_block", 512'(in_ready), 512'(0));
                if (prev_valid && !prev_ready)
                    check(blk_data == held_data && blk_first == held_first && blk_last == held_last,
                          "block_hold_stable", blk_data, held_data);
                if (blk_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_block", blk_data, 512'(0));
                    end else begin
                        e  = exp_q.pop_front();
                        ef = exp_first_q.pop_front();
                        el = exp_last_q.pop_front();
                        check(blk_data == e, "blk_data", blk_data, e);
                        check(blk_first == ef, "blk_first", 512'(blk_first), 512'(ef));
                        check(blk_last == el, "blk_last", 512'(blk_last), 512'(el));
                        $display("block taken: first=%0d last=%0d word0=%08h word15=%08h",
                                 blk_first, blk_last, blk_data[511:480], blk_data[31:0]);
                    end
                end
            end else if (prev_valid && !prev_ready) begin
                check(1'b0, "blk_valid_dropped", 512'(blk_valid), 512'(1));
            end
            prev_valid = blk_valid;
            prev_ready = blk_ready;
            held_data  = blk_data;
            held_first = blk_first;
            held_last  = blk_last;
        end
    end

    task automatic check_all_zero(input string name);
        check({blk_valid, in_ready, blk_first, blk_last, busy} == 5'b0, name,
              512'({blk_valid, in_ready, blk_first, blk_last, busy}), 512'(0));
        check(blk_data == '0, {name, "_data"}, blk_data, 512'(0));
    endtask

    initial begin
        int base, nblk;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset_n = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "in_ready_after_reset", 512'(in_ready), 512'(1));

        // "abc"
        set_msg(0, 3'd3);
        cur_words[0] = 32'h6162_6300;
        model_build(base, nblk);
        check(nblk == 1, "abc_nblk", 512'(nblk), 512'(1));
        check(exp_q[base] == {32'h6162_6380, 448'h0, 32'h0000_0018}, "abc_model", exp_q[base],
              {32'h6162_6380, 448'h0, 32'h0000_0018});
        feed(-1);
        wait_drain();

        // empty message, garbage data must be masked away
        set_msg(0, 3'd0);
        model_build(base, nblk);
        check(exp_q[base] == {32'h8000_0000, 480'h0}, "empty_model", exp_q[base], {32'h8000_0000, 480'h0});
        feed(-1);
        wait_drain();

        // 55 bytes
        set_msg(13, 3'd3);
        model_build(base, nblk);
        check(nblk == 1 && exp_q[base][71:64] == 8'h80 && exp_q[base][31:0] == 32'h1B8, "b55_model",
              512'({exp_q[base][71:64], exp_q[base][31:0]}), 512'({8'h80, 32'h1B8}));
        feed(-1);
        wait_drain();

        // 56 bytes: 14 full words then an empty last word
        set_msg(14, 3'd0);
        model_build(base, nblk);
        check(nblk == 2 && exp_q[base][63:32] == 32'h8000_0000 && exp_q[base + 1] == 512'h1C0,
              "b56_model", exp_q[base + 1], 512'h1C0);
        feed(-1);
        wait_drain();

        // 64 bytes with 5-cycle backpressure on each block; marker overflows into block B
        bp_mode = 1'b1;
        set_msg(15, 3'd4);
        model_build(base, nblk);
        check(nblk == 2 && exp_q[base + 1] == {32'h8000_0000, 448'h0, 32'h0000_0200}, "b64_model",
              exp_q[base + 1], {32'h8000_0000, 448'h0, 32'h0000_0200});
        feed(-1);
        wait_drain();
        bp_mode = 1'b0;

        // 64 bytes as 16 full words and an empty last word
        set_msg(16, 3'd0);
        model_build(base, nblk);
        feed(-1);
        wait_drain();

        // reset after 7 words, then "abc" must come out as a fresh first block
        set_msg(20, 3'd2);
        feed(7);
        check(busy == 1'b1, "busy_before_reset", 512'(busy), 512'(1));
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_msg(0, 3'd3);
        cur_words[0] = 32'h6162_6300;
        model_build(base, nblk);
        feed(-1);
        wait_drain();

        // random messages
        for (int m = 0; m < 40; m++) begin
            set_msg($urandom_range(0, 36), 3'($urandom_range(0, 7)));
            model_build(base, nblk);
            feed(-1);
            wait_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Producer side of the SHA-256 512-bit block interface. Accepts a big-endian 32-bit word stream and applies FIPS 180-4 padding: 0x80 marker, zero fill, and 64-bit message bit length. Emits complete 512-bit blocks, flagged first/last, to the core controller. The controller turns blk_first into init and later blocks into next for the message schedule memory.

Parameters:
LEN_W, 64, width of the internal bit-length counter (legal 16..64). The counter is zero-extended into the 64-bit length field and wraps mod 2^LEN_W.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  padder can accept a word
in_data  in  32  message word; byte0 = [31:24]
in_last  in  1  word is the final word of the message
in_bytes  in  3  valid bytes in the last word (0..4, MSB-aligned); ignored unless in_last; 5..7 treated as 4
blk_valid  out  1  blk_data holds a complete block
blk_ready  in  1  consumer accepts the block
blk_data  out  512  block; word0 = [511:480]
blk_first  out  1  block is the first block of the message
blk_last  out  1  block is the final block of the message
busy  out  1  a message is in progress (words accepted, final block not yet taken)

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, buffer zeroed, word index 0, length 0, first_pending=1, state FILL. Reset mid-message discards everything.
- States: FILL, OUT, EXTRA.
- in_ready = (state == FILL). Handshakes are valid&ready; blk_data is held stable while blk_valid && !blk_ready.
- FILL, word accepted without in_last:
  - Word is written to buffer[widx]; widx increments; length increases by 32.
  - When widx reaches 16, move to OUT with blk_last=0.
- FILL, word accepted with in_last, n = in_bytes, b = 4*widx + n (byte count in this block):
  - Bytes at index n and above within the word are zeroed.
  - Length increases by 8*n.
  - 0x80 goes at byte b if b<64; otherwise pad_pending=1.
  - If b<=55: words 14-15 take the final 64-bit length; move to OUT with blk_last=1.
  - Else: move to OUT with blk_last=0 and extra_pending=1.
  - Length written to words 14-15 includes this word's 8*n bits.
- The transition is registered: blk_valid is high the cycle after the completing word is accepted. Latency is exactly 1 cycle.
- OUT, handshake taken:
  - Buffer is cleared, widx=0, first_pending=0.
  - If extra_pending: move to EXTRA. Else: move to FILL; if blk_last was set, clear length, set first_pending=1, deassert busy.
- EXTRA, one cycle:
  - Builds a zero block with 0x80000000 in word0 if pad_pending, and length in words 14-15.
  - Clears extra_pending and pad_pending; moves to OUT with blk_last=1.
  - blk_valid rises one cycle after entering EXTRA.
- blk_first = first_pending, registered alongside blk_valid. A single-block message has blk_first=blk_last=1.
- Empty message: in_last with in_bytes=0 at widx=0 gives one block of 0x80000000, zeros, length 0.
- in_valid while in_ready=0 is held by the source; no word is lost or duplicated.

Test Plan:
1. "abc": one word 0x61626300, in_bytes=3, last -> one block 0x61626380, words1..13=0, w14=0, w15=0x00000018; first=1, last=1; digest through core = ba7816bf...f20015ad.
2. Empty message: in_last=1, in_bytes=0 -> block word0=0x80000000, rest 0, length 0; first=last=1; blk_valid exactly 1 cycle after the handshake.
3. 55 bytes (13 full words + 3-byte last) -> one block: byte55=0x80, w15=0x000001B8, last=1.
4. 56 bytes (14 full words, then last word with in_bytes=0) -> block A: word14=0x80000000, last=0, first=1; block B: zeros, w15=0x000001C0, first=0, last=1.
5. 64 bytes plus backpressure: hold blk_ready low 5 cycles on each block -> blk_data stable and in_ready=0 throughout; block B word0=0x80000000, w15=0x00000200.
6. Reset after 7 words accepted, then "abc" -> outputs return to 0 immediately; next block identical to scenario 1 with first=1.
